// File: rtl/result_ascii_tx.sv
// result_ascii_tx: converts an 8-bit result to three ASCII decimal digits
// (optionally followed by CR LF) and feeds them to uart_tx one byte at a time.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous reset, active high (1 = reset)
//   start        send request, sampled only while idle
//   value        unsigned result, captured when start is accepted
//   uartbusy     busy flag from uart_tx
//   uart_tx_en   registered one-cycle send strobe
//   uart_tx_data registered byte to send, held until the next load
//   busy         high while a frame is in progress
//   done         one-cycle pulse after the last byte completes
//   error        sticky flag: uart_tx never acknowledged a strobe
module result_ascii_tx #(
  parameter int EOL_EN      = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       uartbusy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_H,
    S_CONV_T,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = (EOL_EN != 0) ? 3'd4 : 3'd2;
  localparam logic [7:0] TMO      = 8'(ACK_TIMEOUT);

  state_t     r_state, w_state;
  logic [7:0] r_rem, w_rem;
  logic [1:0] r_h, w_h;
  logic [3:0] r_t, w_t;
  logic [3:0] r_o, w_o;
  logic [2:0] r_idx, w_idx;
  logic [7:0] r_timer, w_timer;
  logic       r_en, w_en;
  logic [7:0] r_data, w_data;
  logic       r_err, w_err;
  logic [7:0] w_byte;

  always_comb begin
    w_byte = 8'h00;
    unique case (r_idx)
      3'd0:    w_byte = 8'h30 + {6'd0, r_h};
      3'd1:    w_byte = 8'h30 + {4'd0, r_t};
      3'd2:    w_byte = 8'h30 + {4'd0, r_o};
      3'd3:    w_byte = 8'h0D;
      3'd4:    w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_rem   = r_rem;
    w_h     = r_h;
    w_t     = r_t;
    w_o     = r_o;
    w_idx   = r_idx;
    w_timer = r_timer;
    w_en    = 1'b0;
    w_data  = r_data;
    w_err   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rem   = value;
          w_h     = 2'd0;
          w_t     = 4'd0;
          w_err   = 1'b0;
          w_state = S_CONV_H;
        end
      end
      S_CONV_H: begin
        if (r_rem >= 8'd100) begin
          w_rem = r_rem - 8'd100;
          w_h   = r_h + 2'd1;
        end else begin
          w_state = S_CONV_T;
        end
      end
      S_CONV_T: begin
        if (r_rem >= 8'd10) begin
          w_rem = r_rem - 8'd10;
          w_t   = r_t + 4'd1;
        end else begin
          w_o     = r_rem[3:0];
          w_idx   = 3'd0;
          w_state = S_SEND;
        end
      end
      S_SEND: begin
        if (!uartbusy) begin
          w_en    = 1'b1;
          w_data  = w_byte;
          w_timer = 8'd0;
          w_state = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (uartbusy) begin
          w_state = S_WAIT_LO;
        end else if (r_timer == TMO) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + 8'd1;
        end
      end
      S_WAIT_LO: begin
        if (!uartbusy) begin
          if (r_idx == LAST_IDX) begin
            w_state = S_DONE;
          end else begin
            w_idx   = r_idx + 3'd1;
            w_state = S_SEND;
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= 8'd0;
      r_h     <= 2'd0;
      r_t     <= 4'd0;
      r_o     <= 4'd0;
      r_idx   <= 3'd0;
      r_timer <= 8'd0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_rem   <= w_rem;
      r_h     <= w_h;
      r_t     <= w_t;
      r_o     <= w_o;
      r_idx   <= w_idx;
      r_timer <= w_timer;
      r_en    <= w_en;
      r_data  <= w_data;
      r_err   <= w_err;
    end
  end

  assign uart_tx_en   = r_en;
  assign uart_tx_data = r_data;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign error        = r_err;

endmodule
